// File: rtl/addsub_pkg.sv
// Shared encodings for the bit-serial add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Subtraction runs as a + ~b + 1, so a borrow-in removes that +1.
    function automatic logic carry_init(input logic sub, input logic cin);
        return (sub == OP_SUB) ? ~cin : cin;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, reused once per clock by serial_addsub.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full adder stepped over WIDTH clocks, LSB first,
// behind a start/done handshake.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             sub_q;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             accept, last_step;
    logic             bb, s_bit, c_out;

    assign accept    = (state == ST_IDLE) && start;
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign bb        = b_sh[0] ^ sub_q;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (bb),
        .cin  (c_q),
        .s    (s_bit),
        .cout (c_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_step) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                sub_q <= sub;
                c_q   <= carry_init(sub, cin);
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                c_q    <= c_out;
                cnt    <= cnt + CW'(1);
                // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands at the LSB.
                result <= {s_bit, result[WIDTH-1:1]};
                if (last_step) begin
                    carry    <= c_out ^ sub_q;
                    overflow <= c_q ^ c_out;
                end
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized checks of serial_addsub against a behavioural a+/-b model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, carry, overflow;
    logic [W-1:0] result;

    int checks = 0;
    int failures = 0;
    logic [W+1:0] expq[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {overflow, carry, result}
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic ci);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         ov;
        if (s) begin
            full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
            r    = full[W-1:0];
            ov   = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            r    = full[W-1:0];
            ov   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {ov, full[W], r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 4 * W) begin
            tick();
            n++;
        end
        if (busy || done) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Drive one request and consume the accepting edge; expected result goes to the scoreboard.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input logic ci, input bit push);
        wait_idle();
        a = x; b = y; sub = s; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        if (push) expq.push_back(model(x, y, s, ci));
    endtask

    task automatic compare_done(input string tag);
        logic [W+1:0] e;
        if (expq.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = expq.pop_front();
            check({tag, "_result"},   32'(result),   32'(e[W-1:0]));
            check({tag, "_carry"},    32'(carry),    32'(e[W]));
            check({tag, "_overflow"}, 32'(overflow), 32'(e[W+1]));
        end
    endtask

    // Follow an accepted op to its done cycle and check it.
    task automatic finish_op(input string tag, input bit detail);
        for (int i = 1; i <= W; i++) begin
            tick();
            if (i < W) begin
                if (detail) begin
                    check({tag, "_busy_run"}, 32'(busy), 32'd1);
                    check({tag, "_done_run"}, 32'(done), 32'd0);
                end
            end else begin
                check({tag, "_done"}, 32'(done), 32'd1);
                if (detail) check({tag, "_busy_done"}, 32'(busy), 32'd0);
                if (done) compare_done(tag);
            end
        end
        if (detail) begin
            tick();
            check({tag, "_done_drop"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int n, dones;
        logic pb;
        logic [W-1:0] x, y;
        logic [W-1:0] corners [8];

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Basic add with timing
        start_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1);
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        finish_op("t1", 1'b1);

        // Add/sub boundaries
        start_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1); finish_op("add_ff_01", 1'b1);
        start_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1); finish_op("add_7f_01", 1'b1);
        start_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b1); finish_op("sub_05_07", 1'b1);
        start_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b1); finish_op("sub_80_01", 1'b1);
        start_op(8'h10, 8'h0F, 1'b1, 1'b1, 1'b1); finish_op("sub_10_0f_b", 1'b1);

        // Start during RUN is ignored, inputs change after acceptance
        start_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        dones = 0;
        for (int i = 1; i <= W + 12; i++) begin
            if (i == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1; end
            tick();
            if (i == 3) start = 1'b0;
            if (done) begin
                dones++;
                check("ign_done_cycle", 32'(i), 32'(W));
                compare_done("ign");
            end
        end
        check("ign_single_done", 32'(dones), 32'd1);

        // Back-to-back period with start held high
        wait_idle();
        a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        check("b2b_first_accept", 32'(busy), 32'd1);
        pb = busy; n = 0;
        for (int i = 0; i < 4 * W; i++) begin
            tick();
            n++;
            if (busy && !pb) break;
            pb = busy;
        end
        check("b2b_period", 32'(n), 32'(W + 2));
        start = 1'b0;
        n = 0;
        while (!done && n < 4 * W) begin tick(); n++; end
        check("b2b_second_done", 32'(done), 32'd1);
        tick();

        // Reset mid-RUN aborts without a done pulse
        start_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_carry", 32'(carry), 32'd0);
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        start_op(8'h02, 8'h02, 1'b0, 1'b0, 1'b1); finish_op("after_abort", 1'b1);

        // Corner pairs, both modes
        corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h80; corners[3] = 8'h7F;
        corners[4] = 8'h01; corners[5] = 8'hAA; corners[6] = 8'h55; corners[7] = 8'hFE;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int s = 0; s < 2; s++) begin
                    start_op(corners[i], corners[j], s[0], 1'b0, 1'b1);
                    finish_op("corner", 1'b0);
                end

        // Random sweep, both modes, random carry/borrow-in
        for (int k = 0; k < 1200; k++) begin
            x = W'($urandom_range(0, 255));
            y = W'($urandom_range(0, 255));
            start_op(x, y, 1'(k & 1), 1'($urandom_range(0, 1)), 1'b1);
            finish_op("sweep", 1'b0);
        end

        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
